// File: rtl/nn_pkg.sv
// Shared types and fixed-point helpers for the network training sequencer and layer models.
package nn_pkg;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    START_F,
    WAIT_F,
    LOSS,
    START_B,
    WAIT_B,
    NEXT,
    DONE,
    ERROR
  } train_state_t;

  // a - b saturated to a w-bit signed range; operands are sign-extended w-bit values.
  function automatic logic signed [63:0] sat_sub(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int unsigned w);
    logic signed [63:0] d;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    d  = a - b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (d > hi) return hi;
    if (d < lo) return lo;
    return d;
  endfunction

endpackage

// File: rtl/nn_argmax.sv
// Combinational signed argmax over N values; the lowest index wins a tie.
module nn_argmax #(
  parameter int unsigned N     = 2,
  parameter int unsigned W     = 17,
  parameter int unsigned IDX_W = 1
) (
  input  logic [0:N-1][W-1:0] vals,
  output logic [IDX_W-1:0]    idx_c
);

  logic [IDX_W-1:0] best;

  always_comb begin
    best = '0;
    for (int i = 1; i < N; i++) begin
      if ($signed(vals[i]) > $signed(vals[best])) best = IDX_W'(i);
    end
    idx_c = best;
  end

endmodule

// File: rtl/nn_train_ctrl.sv
// Training sequencer: fetch sample, forward pass, output error, backward pass,
// then advance the sample/epoch counters.
module nn_train_ctrl
  import nn_pkg::*;
#(
  parameter int unsigned INPUTS   = 3,
  parameter int unsigned OUTPUTS  = 2,
  parameter int unsigned INT_W    = 9,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned NUM_W    = INT_W + FRAC_W,
  parameter int unsigned SAMPLES  = 4,
  parameter int unsigned EPOCHS   = 16,
  parameter int          RELU_MAX = 1,
  parameter int unsigned TIMEOUT  = 1023,
  parameter int unsigned LABEL_W  = (OUTPUTS > 1) ? $clog2(OUTPUTS) : 1
) (
  input  logic                               clk,
  input  logic                               nreset,
  input  logic                               enable,
  input  logic                               run,
  input  logic                               abort,
  output logic                               sample_req,
  input  logic                               sample_valid,
  input  logic [0:INPUTS-1][NUM_W-1:0]       sample_in,
  input  logic [LABEL_W-1:0]                 sample_label,
  output logic [0:INPUTS-1][NUM_W-1:0]       net_inputs,
  input  logic [0:OUTPUTS-1][NUM_W-1:0]      net_outputs,
  output logic [0:OUTPUTS-1][NUM_W-1:0]      net_outputs_diff,
  output logic                               net_start_f,
  output logic                               net_start_b,
  input  logic                               net_all_ready,
  output logic                               busy,
  output logic                               done,
  output logic                               err_timeout,
  output logic [$clog2(SAMPLES+1)-1:0]       sample_cnt,
  output logic [$clog2(EPOCHS+1)-1:0]        epoch_cnt,
  output logic [$clog2(SAMPLES+1)-1:0]       correct_cnt
);

  localparam int unsigned SCNT_W = $clog2(SAMPLES + 1);
  localparam int unsigned ECNT_W = $clog2(EPOCHS + 1);
  localparam int unsigned TMR_W  = $clog2(TIMEOUT + 1);

  train_state_t                   state_q, state_d;
  logic [TMR_W-1:0]               timer_q, timer_d;
  logic [LABEL_W-1:0]             label_q, label_d;
  logic [SCNT_W-1:0]              run_correct_q, run_correct_d;
  logic [0:INPUTS-1][NUM_W-1:0]   inputs_d;
  logic [0:OUTPUTS-1][NUM_W-1:0]  diff_d;
  logic [SCNT_W-1:0]              sample_cnt_d, correct_cnt_d;
  logic [ECNT_W-1:0]              epoch_cnt_d;
  logic                           err_d;
  logic                           timed_out;
  logic                           is_wait_d;
  logic signed [63:0]             tgt;
  logic [LABEL_W-1:0]             argmax_idx;

  nn_argmax #(
    .N     (OUTPUTS),
    .W     (NUM_W),
    .IDX_W (LABEL_W)
  ) u_argmax (
    .vals  (net_outputs),
    .idx_c (argmax_idx)
  );

  assign timed_out = (timer_q == TMR_W'(TIMEOUT - 1));

  // Next state, counters and datapath; abort overrides everything and freezes counters.
  always_comb begin
    state_d       = state_q;
    label_d       = label_q;
    run_correct_d = run_correct_q;
    inputs_d      = net_inputs;
    diff_d        = net_outputs_diff;
    sample_cnt_d  = sample_cnt;
    epoch_cnt_d   = epoch_cnt;
    correct_cnt_d = correct_cnt;
    err_d         = err_timeout;
    tgt           = '0;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, DONE, ERROR: begin
          if (run) begin
            state_d       = FETCH;
            sample_cnt_d  = '0;
            epoch_cnt_d   = '0;
            correct_cnt_d = '0;
            run_correct_d = '0;
            err_d         = 1'b0;
          end
        end
        FETCH: begin
          if (sample_valid) begin
            inputs_d = sample_in;
            label_d  = sample_label;
            state_d  = START_F;
          end else if (timed_out) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        START_F: state_d = WAIT_F;
        // timer_q == 0 marks the guard cycle right after a start pulse
        WAIT_F, WAIT_B: begin
          if (net_all_ready && timer_q != '0) begin
            state_d = (state_q == WAIT_F) ? LOSS : NEXT;
          end else if (timed_out) begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
        LOSS: begin
          for (int i = 0; i < OUTPUTS; i++) begin
            tgt       = (LABEL_W'(i) == label_q) ? (64'(RELU_MAX) <<< FRAC_W) : '0;
            diff_d[i] = NUM_W'(sat_sub(tgt, 64'($signed(net_outputs[i])), NUM_W));
          end
          if (argmax_idx == label_q) run_correct_d = run_correct_q + SCNT_W'(1);
          state_d = START_B;
        end
        START_B: state_d = WAIT_B;
        NEXT: begin
          if (sample_cnt == SCNT_W'(SAMPLES - 1)) begin
            sample_cnt_d  = '0;
            correct_cnt_d = run_correct_q;
            run_correct_d = '0;
            if (epoch_cnt == ECNT_W'(EPOCHS - 1)) begin
              state_d = DONE;
            end else begin
              epoch_cnt_d = epoch_cnt + ECNT_W'(1);
              state_d     = FETCH;
            end
          end else begin
            sample_cnt_d = sample_cnt + SCNT_W'(1);
            state_d      = FETCH;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Timer restarts on every state change and only counts inside wait states.
    is_wait_d = (state_d == FETCH) || (state_d == WAIT_F) || (state_d == WAIT_B);
    timer_d   = (is_wait_d && state_d == state_q) ? timer_q + TMR_W'(1) : '0;
  end

  // State and registered outputs; enable low freezes everything.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q          <= IDLE;
      timer_q          <= '0;
      label_q          <= '0;
      run_correct_q    <= '0;
      sample_req       <= 1'b0;
      net_inputs       <= '0;
      net_outputs_diff <= '0;
      net_start_f      <= 1'b0;
      net_start_b      <= 1'b0;
      busy             <= 1'b0;
      done             <= 1'b0;
      err_timeout      <= 1'b0;
      sample_cnt       <= '0;
      epoch_cnt        <= '0;
      correct_cnt      <= '0;
    end else if (enable) begin
      state_q          <= state_d;
      timer_q          <= timer_d;
      label_q          <= label_d;
      run_correct_q    <= run_correct_d;
      sample_req       <= (state_d == FETCH);
      net_inputs       <= inputs_d;
      net_outputs_diff <= diff_d;
      net_start_f      <= (state_d == START_F);
      net_start_b      <= (state_d == START_B);
      busy             <= !((state_d == IDLE) || (state_d == DONE) || (state_d == ERROR));
      done             <= (state_d == DONE);
      err_timeout      <= err_d;
      sample_cnt       <= sample_cnt_d;
      epoch_cnt        <= epoch_cnt_d;
      correct_cnt      <= correct_cnt_d;
    end
  end

endmodule

// File: tb/tb_nn_train_ctrl.sv
// Directed bench for nn_train_ctrl: loss/argmax vector table plus hand-written
// sequences for latency, guard cycle, timeout, abort, enable freeze and reset.
module tb_nn_train_ctrl;

  localparam int unsigned NW = 17;
  localparam int unsigned LW = 1;

  logic                clk = 1'b0;
  logic                nreset = 1'b0;
  logic                enable = 1'b1;
  logic                run = 1'b0;
  logic                abort = 1'b0;
  logic                sample_req;
  logic                sample_valid = 1'b0;
  logic [0:2][NW-1:0]  sample_in;
  logic [LW-1:0]       sample_label = '0;
  logic [0:2][NW-1:0]  net_inputs;
  logic [0:1][NW-1:0]  net_outputs = '0;
  logic [0:1][NW-1:0]  net_outputs_diff;
  logic                net_start_f, net_start_b, net_all_ready;
  logic                busy, done, err_timeout;
  logic [1:0]          sample_cnt;
  logic [0:0]          epoch_cnt;
  logic [1:0]          correct_cnt;

  int   mode = 0;      // 0: stub ready 4 cycles after start, 1: ready high, 2: ready low
  int   stub_cnt = 0;
  int   nf_tot = 0;
  int   nb_tot = 0;
  logic sf_prev = 1'b0;
  logic sb_prev = 1'b0;
  int   passed = 0;
  int   total = 0;

  typedef struct {
    logic [LW-1:0] label;
    logic [NW-1:0] o0;
    logic [NW-1:0] o1;
    logic [NW-1:0] d0;
    logic [NW-1:0] d1;
    int            ok;
  } vec_t;
  vec_t tv [6];

  always #5 clk = ~clk;

  assign sample_in = {17'h00123, 17'h1FF00, 17'h00042};

  nn_train_ctrl #(
    .SAMPLES (2),
    .EPOCHS  (1),
    .TIMEOUT (10)
  ) dut (
    .clk              (clk),
    .nreset           (nreset),
    .enable           (enable),
    .run              (run),
    .abort            (abort),
    .sample_req       (sample_req),
    .sample_valid     (sample_valid),
    .sample_in        (sample_in),
    .sample_label     (sample_label),
    .net_inputs       (net_inputs),
    .net_outputs      (net_outputs),
    .net_outputs_diff (net_outputs_diff),
    .net_start_f      (net_start_f),
    .net_start_b      (net_start_b),
    .net_all_ready    (net_all_ready),
    .busy             (busy),
    .done             (done),
    .err_timeout      (err_timeout),
    .sample_cnt       (sample_cnt),
    .epoch_cnt        (epoch_cnt),
    .correct_cnt      (correct_cnt)
  );

  // Layer-chain stub: ready drops on a start pulse and returns 4 cycles later.
  always @(posedge clk) begin
    if (net_start_f || net_start_b) stub_cnt <= 4;
    else if (stub_cnt != 0) stub_cnt <= stub_cnt - 1;
  end
  assign net_all_ready = (mode == 1) || (mode == 0 && stub_cnt == 0);

  // Rising-edge counters for the start pulses.
  always @(posedge clk) begin
    if (net_start_f && !sf_prev) nf_tot <= nf_tot + 1;
    if (net_start_b && !sb_prev) nb_tot <= nb_tot + 1;
    sf_prev <= net_start_f;
    sb_prev <= net_start_b;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Advance until the selected output is high (0: start_f, 1: start_b, 2: done), bounded.
  task automatic wait_for(input int sel, input string name);
    int   n;
    logic hit;
    n   = 0;
    hit = 1'b0;
    while (!hit && n < 400) begin
      tick();
      n++;
      case (sel)
        0:       hit = net_start_f;
        1:       hit = net_start_b;
        default: hit = done;
      endcase
    end
    chk(name, 32'(hit), 32'd1);
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  // One full run of two samples taking table entries a then b.
  task automatic run_pair(input int a, input int b, input bit first);
    int nf0, nb0, k;
    nf0 = nf_tot;
    nb0 = nb_tot;
    sample_label = tv[a].label;
    pulse_run();
    for (int s = 0; s < 2; s++) begin
      k = (s == 0) ? a : b;
      wait_for(0, $sformatf("start_f_v%0d", k));
      net_outputs  = {tv[k].o0, tv[k].o1};
      sample_label = tv[b].label;
      wait_for(1, $sformatf("start_b_v%0d", k));
      chk($sformatf("diff0_v%0d", k), 32'(net_outputs_diff[0]), 32'(tv[k].d0));
      chk($sformatf("diff1_v%0d", k), 32'(net_outputs_diff[1]), 32'(tv[k].d1));
    end
    wait_for(2, $sformatf("done_run_v%0d", a));
    chk($sformatf("correct_cnt_v%0d", a), 32'(correct_cnt), 32'(tv[a].ok + tv[b].ok));
    if (first) begin
      chk("start_f_pulses", 32'(nf_tot - nf0), 32'd2);
      chk("start_b_pulses", 32'(nb_tot - nb0), 32'd2);
      chk("done_sample_cnt", 32'(sample_cnt), 32'd0);
      chk("done_epoch_cnt", 32'(epoch_cnt), 32'd0);
      chk("done_busy", 32'(busy), 32'd0);
      chk("net_inputs0", 32'(net_inputs[0]), 32'h00123);
      chk("net_inputs1", 32'(net_inputs[1]), 32'h1FF00);
    end
  endtask

  initial begin
    int n, b_at, nf0, nb0;
    logic f_seen;

    tv[0] = '{1'b1, 17'h00080, 17'h00300, 17'h1FF80, 17'h1FE00, 1};
    tv[1] = '{1'b0, 17'h10000, 17'h00000, 17'h0FFFF, 17'h00000, 0};
    tv[2] = '{1'b0, 17'h00005, 17'h00005, 17'h000FB, 17'h1FFFB, 1};
    tv[3] = '{1'b1, 17'h00200, 17'h00100, 17'h1FE00, 17'h00000, 0};
    tv[4] = '{1'b0, 17'h0FFFF, 17'h10000, 17'h10101, 17'h0FFFF, 1};
    tv[5] = '{1'b0, 17'h1FFFF, 17'h1FFFE, 17'h00101, 17'h00002, 1};

    // Reset state
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_req", 32'(sample_req), 32'd0);
    chk("rst_starts", 32'({net_start_f, net_start_b, err_timeout}), 32'd0);
    chk("rst_cnts", 32'({sample_cnt, epoch_cnt, correct_cnt}), 32'd0);
    @(negedge clk);
    nreset = 1'b1;
    tick();

    // Loss / argmax table, ideal source, stub network
    sample_valid = 1'b1;
    mode = 0;
    for (int r = 0; r < 3; r++) run_pair(2 * r, 2 * r + 1, r == 0);

    // Latencies, guard cycle and minimum step with ready held high
    mode = 1;
    sample_valid = 1'b0;
    pulse_run();
    chk("req_after_run", 32'(sample_req), 32'd1);
    sample_valid = 1'b1;
    tick();
    chk("start_f_after_valid", 32'(net_start_f), 32'd1);
    chk("req_drop", 32'(sample_req), 32'd0);
    n = 0;
    b_at = 0;
    f_seen = 1'b0;
    while (!f_seen && n < 30) begin
      tick();
      n++;
      if (net_start_b && b_at == 0) b_at = n;
      f_seen = net_start_f;
    end
    chk("f_to_b_cycles", 32'(b_at), 32'd4);
    chk("step_cycles", 32'(n), 32'd9);
    wait_for(2, "done_guard_run");

    // Timeout with ready stuck low, then restart
    mode = 2;
    pulse_run();
    wait_for(0, "start_f_timeout");
    repeat (10) tick();
    chk("err_before_limit", 32'(err_timeout), 32'd0);
    tick();
    chk("err_at_limit", 32'(err_timeout), 32'd1);
    chk("busy_in_error", 32'(busy), 32'd0);
    pulse_run();
    mode = 0;
    chk("err_cleared", 32'(err_timeout), 32'd0);
    chk("req_restart", 32'(sample_req), 32'd1);

    // Abort in WAIT_B of the second sample
    wait_for(1, "start_b_s0");
    wait_for(1, "start_b_s1");
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_sample_cnt", 32'(sample_cnt), 32'd1);
    chk("abort_start_b", 32'(net_start_b), 32'd0);
    nb0 = nb_tot;
    repeat (20) tick();
    chk("abort_no_start_b", 32'(nb_tot - nb0), 32'd0);
    chk("abort_stays_idle", 32'(busy), 32'd0);

    // Enable freeze while the forward start pulse is out
    nf0 = nf_tot;
    pulse_run();
    wait_for(0, "start_f_enable");
    enable = 1'b0;
    repeat (4) tick();
    chk("start_f_held", 32'(net_start_f), 32'd1);
    chk("busy_frozen", 32'(busy), 32'd1);
    enable = 1'b1;
    tick();
    chk("start_f_after_enable", 32'(net_start_f), 32'd0);
    wait_for(2, "done_enable_run");
    chk("start_f_pulses_enable", 32'(nf_tot - nf0), 32'd2);

    // Asynchronous reset in FETCH
    sample_valid = 1'b0;
    pulse_run();
    chk("req_before_reset", 32'(sample_req), 32'd1);
    #2;
    nreset = 1'b0;
    #1;
    chk("areset_req", 32'(sample_req), 32'd0);
    chk("areset_busy", 32'(busy), 32'd0);
    chk("areset_inputs", 32'(net_inputs[0]), 32'd0);
    chk("areset_diff", 32'(net_outputs_diff[0]), 32'd0);
    @(negedge clk);
    nreset = 1'b1;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule

// File: doc/nn_train_ctrl.md
# nn_train_ctrl

Training sequencer for the layer chain of the network. Fetches one labelled sample per step from a sample source, pulses `start_f`, waits for the chain's `all_ready`, computes the output-error vector (`outputs_diff`), pulses `start_b`, waits again, then advances sample/epoch counters. It sits between the sample source and the layer chain (with its shared RAM/MULT wrappers) and replaces the hand-written stimulus sequence in the network benches.

## Interface
- `INPUTS`, 3, network input count
- `OUTPUTS`, 2, network output count
- `INT_W`, 9, integer bits of fixed-point number
- `FRAC_W`, 8, fraction bits
- `NUM_W`, INT_W+FRAC_W, number width
- `SAMPLES`, 4, samples per epoch (≥1)
- `EPOCHS`, 16, epochs per run (≥1)
- `RELU_MAX`, 1, target value for the labelled output (integer, scaled by `2**FRAC_W`)
- `TIMEOUT`, 1023, max cycles in any wait state (≥2)
- `LABEL_W`, max(1,$clog2(OUTPUTS)), label width

Ports:
- `clk`  in  1  clock
- `nreset`  in  1  asynchronous active-low reset
- `enable`  in  1  clock enable; when low all state and outputs hold
- `run`  in  1  start a run (sampled in IDLE, DONE, ERROR)
- `abort`  in  1  return to IDLE
- `sample_req`  out  1  request next sample
- `sample_valid`  in  1  sample present on `sample_in`/`sample_label`
- `sample_in`  in  NUM_W × [0:INPUTS-1]  signed sample
- `sample_label`  in  LABEL_W  target output index
- `net_inputs`  out  NUM_W × [0:INPUTS-1]  registered network inputs
- `net_outputs`  in  NUM_W × [0:OUTPUTS-1]  signed network outputs
- `net_outputs_diff`  out  NUM_W × [0:OUTPUTS-1]  registered error vector
- `net_start_f`, `net_start_b`  out  1  one-cycle start pulses
- `net_all_ready`  in  1  AND of all layer `ready_out`
- `busy`, `done`, `err_timeout`  out  1  status
- `sample_cnt`  out  $clog2(SAMPLES+1)  current sample index
- `epoch_cnt`  out  $clog2(EPOCHS+1)  current epoch index
- `correct_cnt`  out  $clog2(SAMPLES+1)  correct predictions in the last completed epoch

## Operation
- States: IDLE, FETCH, START_F, WAIT_F, LOSS, START_B, WAIT_B, NEXT, DONE, ERROR.
- IDLE/DONE/ERROR + `run`: clear counters, `done`, `err_timeout`, the running correct counter → FETCH.
- FETCH: `sample_req`=1. On `sample_valid`, latch `sample_in`→`net_inputs` and latch the label → START_F.
- START_F: `net_start_f`=1 for one cycle → WAIT_F.
- WAIT_F: ignore `net_all_ready` in the first cycle (guard). Afterwards, `net_all_ready`=1 → LOSS.
- LOSS: `net_outputs_diff[i]` = sat((i==label ? RELU_MAX<<FRAC_W : 0) − `net_outputs[i]`).
  - Compute in NUM_W+1 bits and saturate to [−2^(NUM_W−1), 2^(NUM_W−1)−1].
  - Argmax of `net_outputs` (signed; lowest index wins ties) == label → increment the running correct counter.
  - → START_B.
- START_B / WAIT_B: same as START_F / WAIT_F with `net_start_b` → NEXT.
- NEXT:
  - If `sample_cnt`==SAMPLES−1: `sample_cnt`←0; `correct_cnt`←running count (including the sample just counted); reset the running count.
    - If `epoch_cnt`==EPOCHS−1 → DONE; otherwise increment `epoch_cnt` → FETCH.
  - Otherwise increment `sample_cnt` → FETCH.
- Timeout: a cycle counter runs in FETCH, WAIT_F and WAIT_B and reloads on state entry. Reaching TIMEOUT → ERROR with `err_timeout`=1.
- `abort` has priority over all transitions: next state IDLE, start pulses low, counters hold, `done`=0.
- `busy`=1 in every state except IDLE, DONE and ERROR. `done`=1 only in DONE.

## Timing
- Reset values: all outputs 0, including `net_inputs`, `net_outputs_diff` and all counters; state IDLE.
- `run` in IDLE → `sample_req` high the next cycle.
- `sample_valid` in FETCH → `net_start_f` high the next cycle, and for exactly one cycle.
- Earliest LOSS: 3 cycles after `net_start_f` (guard cycle, then ready seen).
- `net_outputs_diff` is valid from the cycle `net_start_b` is high, and holds until the next LOSS.
- Minimum step: 9 cycles per sample with `sample_valid` and `net_all_ready` held high.
- `enable`=0 freezes the FSM, counters and timeout counter. A pending start pulse is emitted after `enable` returns; it is never duplicated.
- Asynchronous reset mid-operation returns to IDLE immediately; a start pulse in flight is dropped.

## Structure
- A shared package `nn_pkg` holds the state enum `train_state_t` and the saturation helper `sat_sub` (also usable by LAYER_TEST models).
- One sub-module, `nn_argmax` (combinational, OUTPUTS × NUM_W signed in, index out, lowest index on tie), instantiated in LOSS.

## Test plan
- Basic run (SAMPLES=2, EPOCHS=1, ideal source, stub network with ready 4 cycles after each start):
  - exactly 2 `net_start_f` and 2 `net_start_b` pulses;
  - `done`=1 with `epoch_cnt`=0, `sample_cnt`=0.
- Loss value (label=1, FRAC_W=8, outputs {0x0080, 0x0300}):
  - `net_outputs_diff` = {−0x0080, −0x0200};
  - argmax=1, so correct +1.
- Saturation: output[0]=−2^16 with label=0 → diff[0]=0x0FFFF (max positive), no wrap.
- Guard cycle: `net_all_ready` held permanently high → WAIT_F still lasts exactly 2 cycles; no premature `net_start_b`.
- Timeout (TIMEOUT=10, `net_all_ready` stuck low after start) → `err_timeout`=1 exactly 10 cycles after WAIT_F entry. A following `run` clears it and restarts.
- Abort and reset:
  - `abort` in WAIT_B → IDLE next cycle, `busy`=0, `net_start_b` never pulses.
  - `nreset` low mid-FETCH → all outputs 0 asynchronously.
